// File: rtl/piece_queue_ctrl.sv
// rtl/piece_queue_ctrl.sv - piece RNG sequencer and preview queue; optional PIECE_BAG_EN bag mode
module piece_queue_ctrl #(
    parameter int PIECE_W    = 2,
    parameter int DEPTH      = 3,
    parameter int MAX_REROLL = 3
) (
    input  logic                       clka,
    input  logic                       restart,
    input  logic                       enable,
    input  logic [PIECE_W-1:0]         random,
    input  logic                       piece_req,
    output logic                       rng_restart,
    output logic                       piece_vld,
    output logic [PIECE_W-1:0]         piece,
    output logic [PIECE_W-1:0]         preview,
    output logic [$clog2(DEPTH+1)-1:0] queue_cnt
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NCODE = 1 << PIECE_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PIECE_W-1:0]   q_q [DEPTH];
    logic [PIECE_W-1:0]   q_d [DEPTH];

`ifdef PIECE_BAG_EN
    logic [NCODE-1:0]     bag_q, bag_d;
    logic [NCODE-1:0]     bag_set;
`else
    localparam int RW = (MAX_REROLL < 1) ? 1 : $clog2(MAX_REROLL + 1);
    logic                 has_last_q, has_last_d;
    logic [PIECE_W-1:0]   last_q, last_d;
    logic [RW-1:0]        reroll_q, reroll_d;
    logic                 repeat_hit;
`endif

    logic                 run;
    logic                 pop;
    logic                 slot;
    logic                 accept;
    logic [CW-1:0]        widx;

    // State register, queue storage and candidate-filter history
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
`ifdef PIECE_BAG_EN
            bag_q   <= '0;
`else
            has_last_q <= 1'b0;
            last_q     <= '0;
            reroll_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
`ifdef PIECE_BAG_EN
            bag_q   <= bag_d;
`else
            has_last_q <= has_last_d;
            last_q     <= last_d;
            reroll_q   <= reroll_d;
`endif
        end
    end

    // Next state, pop/push decision, queue shift and flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < DEPTH; i++) q_d[i] = q_q[i];
`ifdef PIECE_BAG_EN
        bag_d   = bag_q;
        bag_set = bag_q | (NCODE'(1) << random);
`else
        has_last_d = has_last_q;
        last_d     = last_q;
        reroll_d   = reroll_q;
        repeat_hit = has_last_q && (random == last_q);
`endif

        run  = (state_q == S_RUN);
        pop  = run && piece_req && (cnt_q != '0);
        // A slot exists when there is room, or when a pop frees one on this edge.
        slot = run && ((cnt_q < CW'(DEPTH)) || pop);
`ifdef PIECE_BAG_EN
        accept = slot && !bag_q[random];
`else
        accept = slot && (!repeat_hit || (reroll_q == RW'(MAX_REROLL)));
`endif
        widx = pop ? (cnt_q - CW'(1)) : cnt_q;

        case (state_q)
            S_IDLE:  if (enable) state_d = S_SEED;
            S_SEED:  state_d = enable ? S_RUN : S_IDLE;
            S_RUN:   if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Shift in zeros so slots beyond the tail always read as 0.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i + 1];
            q_d[DEPTH-1] = '0;
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (widx == CW'(i)) q_d[i] = random;
            end
        end

        if (accept && !pop) cnt_d = cnt_q + CW'(1);
        else if (!accept && pop) cnt_d = cnt_q - CW'(1);

`ifdef PIECE_BAG_EN
        if (accept) bag_d = (&bag_set) ? '0 : bag_set;
`else
        if (accept) begin
            has_last_d = 1'b1;
            last_d     = random;
            reroll_d   = '0;
        end else if (slot) begin
            reroll_d   = reroll_q + RW'(1);
        end
`endif

        // Leaving RUN discards the queue, any pending pop and all filter history.
        if (run && !enable) begin
            cnt_d = '0;
            for (int i = 0; i < DEPTH; i++) q_d[i] = '0;
`ifdef PIECE_BAG_EN
            bag_d = '0;
`else
            has_last_d = 1'b0;
            last_d     = '0;
            reroll_d   = '0;
`endif
        end
    end

    // Outputs decode directly from registered state
    always_comb begin
        rng_restart = (state_q == S_SEED);
        piece_vld   = (state_q == S_RUN) && (cnt_q != '0);
        piece       = q_q[0];
        preview     = (cnt_q >= CW'(2)) ? q_q[1] : '0;
        queue_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// tb/tb_piece_queue_ctrl.sv - self-checking bench for piece_queue_ctrl
module tb_piece_queue_ctrl;

    localparam int PW = 2;
    localparam int D  = 3;
    localparam int MR = 3;
    localparam int CW = $clog2(D + 1);

    logic          clka = 1'b0;
    logic          restart;
    logic          enable;
    logic [PW-1:0] random;
    logic          piece_req;
    logic          rng_restart;
    logic          piece_vld;
    logic [PW-1:0] piece;
    logic [PW-1:0] preview;
    logic [CW-1:0] queue_cnt;

    int errors = 0;
    int checks = 0;

    piece_queue_ctrl #(.PIECE_W(PW), .DEPTH(D), .MAX_REROLL(MR)) dut (
        .clka(clka), .restart(restart), .enable(enable), .random(random),
        .piece_req(piece_req), .rng_restart(rng_restart), .piece_vld(piece_vld),
        .piece(piece), .preview(preview), .queue_cnt(queue_cnt)
    );

    always #5 clka = ~clka;

    // Reference model: phase 0=idle 1=seed 2=run, queue of pieces, filter history
    int   m_phase;
    int   mq[$];
    bit   m_has_last;
    int   m_last;
    int   m_reroll;
    bit   m_bag[4];
    int   dut_pops[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic m_clear();
        mq.delete();
        m_has_last = 1'b0;
        m_last     = 0;
        m_reroll   = 0;
        for (int i = 0; i < 4; i++) m_bag[i] = 1'b0;
    endtask

    task automatic m_step(input bit en, input int rnd, input bit req);
        bit pop, slot, ok, full;
        case (m_phase)
            0: if (en) m_phase = 1;
            1: m_phase = en ? 2 : 0;
            default: begin
                if (!en) begin
                    m_clear();
                    m_phase = 0;
                end else begin
                    pop  = req && (mq.size() > 0);
                    slot = (mq.size() < D) || pop;
                    if (pop) void'(mq.pop_front());
                    if (slot) begin
`ifdef PIECE_BAG_EN
                        ok = !m_bag[rnd];
`else
                        ok = !m_has_last || (rnd != m_last) || (m_reroll >= MR);
`endif
                        if (ok) begin
                            mq.push_back(rnd);
                            m_has_last = 1'b1;
                            m_last     = rnd;
                            m_reroll   = 0;
                            m_bag[rnd] = 1'b1;
                            full = 1'b1;
                            for (int i = 0; i < 4; i++) full &= m_bag[i];
                            if (full) for (int i = 0; i < 4; i++) m_bag[i] = 1'b0;
                        end else begin
                            m_reroll++;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, "_vld"},     int'(piece_vld),   int'(m_phase == 2 && sz > 0));
        chk({tag, "_piece"},   int'(piece),       (sz > 0) ? mq[0] : 0);
        chk({tag, "_preview"}, int'(preview),     (sz > 1) ? mq[1] : 0);
        chk({tag, "_cnt"},     int'(queue_cnt),   sz);
        chk({tag, "_rngrst"},  int'(rng_restart), int'(m_phase == 1));
    endtask

    // Called just after a falling edge: apply inputs, check, advance one clock.
    task automatic cycle(input bit en, input int rnd, input bit req, input string tag);
        enable    = en;
        random    = PW'(rnd);
        piece_req = req;
        #1;
        check_model(tag);
        if (req && piece_vld) dut_pops.push_back(int'(piece));
        m_step(en, rnd, req);
        @(posedge clka);
        @(negedge clka);
    endtask

    // Reset is raised between edges and checked before any clock edge arrives.
    task automatic do_reset(input string tag);
        #2;
        restart   = 1'b1;
        enable    = 1'b0;
        piece_req = 1'b0;
        random    = '0;
        #1;
        m_phase = 0;
        m_clear();
        check_model(tag);
        @(posedge clka);
        @(negedge clka);
        restart = 1'b0;
    endtask

    typedef struct {
        bit en; int rnd; bit req;
        bit vld; int pc; int pv; int cnt; bit rr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int prev_rnd;
        int en_r, rnd_r, req_r;
        int mask;

        restart = 1'b0; enable = 1'b0; piece_req = 1'b0; random = '0;
        @(negedge clka);

        // Seed, fill 1,2,3, full pop+push, flush with pending pop, re-seed
        tbl[0]  = '{1, 1, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0,  0, 0, 0, 0, 1};
        tbl[2]  = '{1, 1, 0,  0, 0, 0, 0, 0};
        tbl[3]  = '{1, 2, 0,  1, 1, 0, 1, 0};
        tbl[4]  = '{1, 3, 0,  1, 1, 2, 2, 0};
        tbl[5]  = '{1, 0, 1,  1, 1, 2, 3, 0};
        tbl[6]  = '{1, 0, 0,  1, 2, 3, 3, 0};
        tbl[7]  = '{0, 0, 1,  1, 2, 3, 3, 0};
        tbl[8]  = '{0, 0, 0,  0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0,  0, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 0,  0, 0, 0, 0, 1};

        do_reset("reset");
        for (int i = 0; i < 11; i++) begin
            enable = tbl[i].en; random = PW'(tbl[i].rnd); piece_req = tbl[i].req;
            #1;
            chk($sformatf("tbl%0d_vld", i),     int'(piece_vld),   int'(tbl[i].vld));
            chk($sformatf("tbl%0d_piece", i),   int'(piece),       tbl[i].pc);
            chk($sformatf("tbl%0d_preview", i), int'(preview),     tbl[i].pv);
            chk($sformatf("tbl%0d_cnt", i),     int'(queue_cnt),   tbl[i].cnt);
            chk($sformatf("tbl%0d_rngrst", i),  int'(rng_restart), int'(tbl[i].rr));
            cycle(tbl[i].en, tbl[i].rnd, tbl[i].req, $sformatf("tblm%0d", i));
        end

        // Async restart while the queue holds entries
        cycle(1, 2, 0, "mid0");
        cycle(1, 3, 0, "mid1");
        do_reset("async_mid");

        // Enable dropped during SEED returns to idle without pushing
        cycle(1, 1, 0, "sd0");
        cycle(0, 1, 0, "sd1");
        cycle(0, 1, 0, "sd2");
        chk("seed_drop_cnt", int'(queue_cnt), 0);

`ifndef PIECE_BAG_EN
        // Repeat cap: 3 rejects of 2, forced accept on the 4th, counter back to 0
        do_reset("rep_reset");
        cycle(1, 0, 0, "rep_i");
        cycle(1, 0, 0, "rep_s");
        cycle(1, 2, 0, "rep_p");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rep_reject%0d_cnt", k), int'(queue_cnt), 1);
            cycle(1, 2, 0, $sformatf("rep_r%0d", k));
        end
        chk("rep_before_forced_cnt", int'(queue_cnt), 1);
        cycle(1, 2, 0, "rep_f");
        chk("rep_forced_cnt", int'(queue_cnt), 2);
        chk("rep_forced_preview", int'(preview), 2);
        cycle(1, 2, 0, "rep_after");
        chk("rep_rearmed_cnt", int'(queue_cnt), 2);
`else
        // Bag: the first four served pieces form a permutation of all codes
        do_reset("bag_reset");
        dut_pops.delete();
        cycle(1, 0, 0, "bag_i");
        cycle(1, 0, 0, "bag_s");
        begin
            int seq[12] = '{0, 0, 1, 1, 2, 3, 3, 0, 1, 2, 3, 0};
            for (int k = 0; k < 12; k++) cycle(1, seq[k], 1, $sformatf("bag%0d", k));
        end
        chk("bag_pops_ge4", int'(dut_pops.size() >= 4), 1);
        mask = 0;
        for (int k = 0; k < 4 && k < dut_pops.size(); k++) mask |= (1 << dut_pops[k]);
        chk("bag_perm_mask", mask, 15);
        cycle(1, 1, 0, "bag_pre_rst");
        do_reset("bag_async");
`endif

        // Randomized run against the model
        do_reset("rnd_reset");
        prev_rnd = 0;
        for (int n = 0; n < 500; n++) begin
            en_r  = ($urandom_range(0, 39) != 0) ? 1 : 0;
            rnd_r = ($urandom_range(0, 2) == 0) ? prev_rnd : int'($urandom_range(0, 3));
            req_r = int'($urandom_range(0, 2) == 0);
            prev_rnd = rnd_r;
            cycle(en_r[0], rnd_r, req_r[0], $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
